// File: rtl/iob_wishbone2iob.sv
// Wishbone B4 slave to IOb master bridge: one transfer in flight, every output registered.
// A master that drops cyc mid-transfer still sees its IOb access drained, but gets no ack.
module iob_wishbone2iob #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic                wb_ack_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RDATA, ACK} state_t;

  state_t              state_reg, state_next;
  logic                abort_reg, abort_next;
  logic                ack_reg, ack_next;
  logic                avalid_reg, avalid_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                abort_now;

  // Abort is sticky: once cyc drops, the in-flight access finishes silently.
  assign abort_now = abort_reg | ~wb_cyc_i;

  always_comb begin
    state_next = state_reg;
    abort_next = abort_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_next  = wb_addr_i;
          wdata_next = wb_data_i;
          wstrb_next = wb_we_i ? wb_select_i : '0;
          abort_next = 1'b0;
          if (wb_we_i && (wb_select_i == '0)) state_next = ACK;
          else                                state_next = REQ;
        end
      end
      REQ: begin
        abort_next = abort_now;
        if (iob_ready_i) begin
          if (|wstrb_reg) state_next = abort_now ? IDLE : ACK;
          else            state_next = RDATA;
        end
      end
      RDATA: begin
        abort_next = abort_now;
        if (iob_rvalid_i) begin
          rdata_next = iob_rdata_i;
          state_next = abort_now ? IDLE : ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    avalid_next = (state_next == REQ);
    ack_next    = (state_next == ACK);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg  <= IDLE;
      abort_reg  <= 1'b0;
      ack_reg    <= 1'b0;
      avalid_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      rdata_reg  <= '0;
    end else if (cke_i) begin
      state_reg  <= state_next;
      abort_reg  <= abort_next;
      ack_reg    <= ack_next;
      avalid_reg <= avalid_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      wstrb_reg  <= wstrb_next;
      rdata_reg  <= rdata_next;
    end
  end

  assign wb_ack_o     = ack_reg;
  assign wb_data_o    = rdata_reg;
  assign iob_avalid_o = avalid_reg;
  assign iob_addr_o   = addr_reg;
  assign iob_wdata_o  = wdata_reg;
  assign iob_wstrb_o  = wstrb_reg;

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Bench for iob_wishbone2iob: acts as Wishbone master and IOb memory slave, with expected
// timing taken from the latency rules and read data from a byte-enabled word memory model.
module tb_iob_wishbone2iob;

  logic        clk = 1'b0;
  logic        cke, arst;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic        wb_we, cyc, stb, ack;
  logic        avalid, ready, rvalid;
  logic [31:0] iob_addr, iob_wdata, iob_rdata;
  logic [3:0]  iob_wstrb;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [0:15];
  logic [31:0] last_rd;

  iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .wb_addr_i(wb_addr), .wb_select_i(wb_sel), .wb_we_i(wb_we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_data_i(wb_wdata),
    .wb_ack_o(ack), .wb_data_o(wb_rdata),
    .iob_avalid_o(avalid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(ready), .iob_rvalid_i(rvalid),
    .iob_rdata_i(iob_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Memory model: byte-enabled write into a word array indexed by addr[5:2].
  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    for (int b = 0; b < 4; b++)
      if (sel[b]) mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  // One Wishbone transfer starting at the current negedge (cycle 0). rw/vw are wait cycles
  // before ready/rvalid; abort_at>0 drops cyc at that cycle; keep_stb leaves stb high after ack.
  task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int rw, input int vw,
                          input int abort_at, input bit keep_stb);
    int          ack_c;
    logic        skip;
    logic        exp_av, exp_ack;
    logic [31:0] rd_new, exp_wbd;
    logic [3:0]  exp_strb;
    skip     = we && (sel == 4'h0);
    ack_c    = skip ? 1 : (we ? 2 + rw : 3 + rw + vw);
    exp_strb = we ? sel : 4'h0;
    rd_new   = mem[addr[5:2]];
    cyc = 1'b1; stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = data; wb_sel = sel;
    checks++;
    if (avalid !== 1'b0) begin
      errors++; $display("FAIL idle_avalid: got %b exp 0", avalid);
    end
    for (int c = 1; c <= ack_c; c++) begin
      @(negedge clk);
      exp_av  = !skip && (c <= 1 + rw);
      exp_ack = (abort_at == 0) && (c == ack_c);
      exp_wbd = (!we && c == ack_c) ? rd_new : last_rd;
      checks++;
      if (avalid !== exp_av) begin
        errors++; $display("FAIL avalid c%0d: got %b exp %b", c, avalid, exp_av);
      end
      if (exp_av) begin
        checks++;
        if (iob_addr !== addr || iob_wdata !== data || iob_wstrb !== exp_strb) begin
          errors++;
          $display("FAIL req_fields c%0d: got %h/%h/%h exp %h/%h/%h", c,
                   iob_addr, iob_wdata, iob_wstrb, addr, data, exp_strb);
        end
      end
      checks++;
      if (ack !== exp_ack) begin
        errors++; $display("FAIL ack c%0d: got %b exp %b", c, ack, exp_ack);
      end
      checks++;
      if (wb_rdata !== exp_wbd) begin
        errors++; $display("FAIL wb_data c%0d: got %h exp %h", c, wb_rdata, exp_wbd);
      end
      ready = exp_av && (c == 1 + rw);
      if (ready && we) mem_write(addr, data, sel);
      if (!we && c == 2 + rw + vw) begin
        rvalid = 1'b1; iob_rdata = rd_new;
      end else if (we || c <= 1 + rw || c == ack_c) begin
        rvalid = 1'($urandom_range(0, 1)); iob_rdata = $urandom;
      end else begin
        rvalid = 1'b0; iob_rdata = $urandom;
      end
      if (c == abort_at) begin
        cyc = 1'b0; stb = 1'b0;
      end
      if (c == ack_c && !keep_stb) begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
    @(negedge clk);
    ready = 1'b0; rvalid = 1'b0;
    if (!we) last_rd = rd_new;
    checks++;
    if (ack !== 1'b0 || avalid !== 1'b0) begin
      errors++; $display("FAIL post_xfer: got ack=%b avalid=%b exp 0/0", ack, avalid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ack, avalid, iob_wstrb} !== 6'h0 || iob_addr !== 32'h0 || iob_wdata !== 32'h0 ||
        wb_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got ack=%b av=%b a=%h w=%h s=%h d=%h exp all 0",
               ack, avalid, iob_addr, iob_wdata, iob_wstrb, wb_rdata);
    end
    arst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || avalid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got ack=%b avalid=%b exp 0/0", ack, avalid);
    end
  endtask

  task automatic test_write_basic();
    run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);
  endtask

  task automatic test_read_basic();
    run_xfer(1'b0, 32'h20, 32'h0, 4'hF, 0, 2, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (wb_rdata !== 32'h12345678) begin
      errors++; $display("FAIL read_hold: got %h exp 12345678", wb_rdata);
    end
  endtask

  task automatic test_write_wait();
    run_xfer(1'b1, 32'h14, 32'hA5A55A5A, 4'h6, 3, 0, 0, 1'b0);
  endtask

  task automatic test_sel_zero();
    run_xfer(1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_abort_read();
    run_xfer(1'b0, 32'h10, 32'h0, 4'hF, 0, 3, 3, 1'b0);
    run_xfer(1'b0, 32'h14, 32'h0, 4'hF, 1, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cyc = 1'b1; stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h20; wb_sel = 4'hF;
    @(negedge clk);
    checks++;
    if (avalid !== 1'b1) begin
      errors++; $display("FAIL mid_avalid: got %b exp 1", avalid);
    end
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({ack, avalid, iob_wstrb} !== 6'h0 || iob_addr !== 32'h0 || iob_wdata !== 32'h0 ||
        wb_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got ack=%b av=%b a=%h w=%h s=%h d=%h exp all 0",
               ack, avalid, iob_addr, iob_wdata, iob_wstrb, wb_rdata);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    last_rd = 32'h0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || avalid !== 1'b0) begin
        errors++; $display("FAIL after_reset: got ack=%b avalid=%b exp 0/0", ack, avalid);
      end
    end
    run_xfer(1'b0, 32'h20, 32'h0, 4'hF, 0, 0, 0, 1'b0);
  endtask

  task automatic test_cke();
    logic [31:0] d;
    d = $urandom;
    cyc = 1'b1; stb = 1'b1; wb_we = 1'b1; wb_addr = 32'h44; wb_wdata = d; wb_sel = 4'hF;
    @(negedge clk);
    checks++;
    if (avalid !== 1'b1) begin
      errors++; $display("FAIL cke_start: got %b exp 1", avalid);
    end
    cke = 1'b0; ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (avalid !== 1'b1 || ack !== 1'b0 || iob_wdata !== d) begin
        errors++;
        $display("FAIL cke_freeze_req: got av=%b ack=%b w=%h exp 1/0/%h", avalid, ack, iob_wdata, d);
      end
    end
    cke = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || avalid !== 1'b0) begin
      errors++; $display("FAIL cke_resume: got ack=%b av=%b exp 1/0", ack, avalid);
    end
    mem_write(32'h44, d, 4'hF);
    cke = 1'b0; ready = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL cke_hold_ack: got %b exp 1", ack);
    end
    cke = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("FAIL cke_ack_end: got %b exp 0", ack);
    end
    run_xfer(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [3:0]  sel;
      int          rw, vw, ab, ack_c;
      bit          keep;
      we   = 1'($urandom_range(0, 1));
      sel  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      rw   = $urandom_range(0, 3);
      vw   = $urandom_range(0, 3);
      keep = (n != 39) && ($urandom_range(0, 1) == 1);
      ack_c = we ? 2 + rw : 3 + rw + vw;
      ab   = (!(we && sel == 4'h0) && $urandom_range(0, 4) == 0) ? $urandom_range(1, ack_c - 1) : 0;
      run_xfer(we, {26'($urandom), 4'($urandom), 2'b00}, $urandom, sel, rw, vw, ab, keep);
      if (!keep && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        checks++;
        if (avalid !== 1'b0 || ack !== 1'b0) begin
          errors++; $display("FAIL gap_idle: got av=%b ack=%b exp 0/0", avalid, ack);
        end
      end
    end
  endtask

  initial begin
    arst = 1'b1; cke = 1'b1;
    cyc = 1'b0; stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0; wb_sel = '0;
    ready = 1'b0; rvalid = 1'b0; iob_rdata = '0;
    last_rd = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[8] = 32'h12345678;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_wait();
    test_sel_zero();
    test_abort_read();
    test_reset_mid();
    test_cke();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iob_wishbone2iob.md
IOB_WISHBONE2IOB -- requirements
Module: iob_wishbone2iob

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width, both buses.
REQ-002 SHALL have parameter DATA_W, default 32: data width, both buses; multiple of 8.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; clock and reset ports listed first:
 clk_i  in  1  clock, rising edge;
 cke_i  in  1  clock enable; low freezes all state;
 arst_i  in  1  asynchronous active-high reset.
REQ-004 Wishbone slave ports SHALL be:
 wb_addr_i  in  ADDR_W  address;
 wb_select_i  in  DATA_W/8  byte select;
 wb_we_i  in  1  write enable;
 wb_cyc_i  in  1  cycle;
 wb_stb_i  in  1  strobe;
 wb_data_i  in  DATA_W  write data;
 wb_ack_o  out  1  acknowledge;
 wb_data_o  out  DATA_W  read data.
REQ-005 IOb master ports SHALL be:
 iob_avalid_o  out  1  request valid;
 iob_addr_o  out  ADDR_W  address;
 iob_wdata_o  out  DATA_W  write data;
 iob_wstrb_o  out  DATA_W/8  write strobe (0 = read);
 iob_ready_i  in  1  request accepted;
 iob_rvalid_i  in  1  read data valid;
 iob_rdata_i  in  DATA_W  read data.

Function
REQ-006 SHALL implement FSM with states IDLE, REQ, RDATA, ACK; all outputs registered.
REQ-007 IDLE: on wb_cyc_i&wb_stb_i SHALL capture wb_addr_i, wb_data_i, and wstrb = wb_we_i ? wb_select_i : 0, then go to REQ.
REQ-008 IDLE, write with wb_select_i==0: SHALL skip the IOb access and go directly to ACK.
REQ-009 REQ: iob_avalid_o SHALL be 1, with addr/wdata/wstrb stable until the cycle iob_ready_i=1.
REQ-010 REQ with iob_ready_i=1: write SHALL go to ACK; read SHALL go to RDATA.
REQ-011 RDATA: on iob_rvalid_i=1 SHALL capture iob_rdata_i into wb_data_o and go to ACK.
REQ-012 rvalid SHALL be honoured only in RDATA; rvalid in IDLE, REQ or ACK SHALL be ignored.
REQ-013 ACK: wb_ack_o SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-014 wb_data_o SHALL hold its value until the next read completes.
REQ-015 Latency from stb sampled in IDLE (cycle 0), ready same cycle as avalid:
 write: avalid cycle 1, ack cycle 2;
 read, rvalid cycle 2: ack cycle 3.
 Each wait cycle on ready or rvalid adds one cycle.
REQ-016 Back-to-back transfers: a stb still high in IDLE after ack SHALL start a new transfer; at most one IOb request outstanding.
REQ-017 Abort, wb_cyc_i low during REQ or RDATA:
 IOb request SHALL still complete (avalid held until ready; read drained until rvalid);
 ACK SHALL be skipped and the FSM SHALL return to IDLE;
 wb_data_o SHALL still update on a drained read.
REQ-018 cke_i=0: state, outputs and captured data SHALL hold; wb_ack_o held at its current value.

Reset
REQ-019 arst_i=1 SHALL asynchronously force:
 state to IDLE;
 wb_ack_o, iob_avalid_o to 0;
 iob_addr_o, iob_wdata_o, iob_wstrb_o, wb_data_o to 0.
REQ-020 Reset mid-transfer SHALL drop iob_avalid_o immediately; no ack SHALL be issued for the interrupted transfer.

Verification
REQ-021 Write, addr 0x10, data 0xDEADBEEF, sel 0xF, ready tied 1 -> avalid cycle 1 with wstrb 0xF; single ack pulse cycle 2.
REQ-022 Read, addr 0x20, ready 1, rvalid cycle 4 with rdata 0x12345678 -> ack cycle 5; wb_data_o=0x12345678 held after.
REQ-023 Write, ready delayed 3 cycles -> avalid/addr/wdata stable over 4 cycles; ack exactly 1 cycle after ready.
REQ-024 Write, sel 0x0 -> avalid never asserted; ack cycle 1.
REQ-025 Read, cyc dropped in RDATA -> avalid completes; rdata captured; no ack; next stb accepted normally.
REQ-026 arst_i pulse during REQ -> avalid 0 asynchronously; all outputs 0; FSM in IDLE.
